// File: rtl/axis_dac_arbiter_pkg.sv
// ============================================================================
// Module : axis_dac_arbiter_pkg
// Brief  : Shared state encoding and configuration field layout for the
//          two-source AXI4-Stream DAC arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axis_dac_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int SRC_NUM = 2;

    // cfg_data is split into CNTR_WIDTH-wide fields; these are field indices
    localparam int c_cfg_max_idx   = 0;
    localparam int c_cfg_guard_idx = 1;

endpackage

`default_nettype wire

// File: rtl/axis_dac_arbiter_oreg.sv
// ============================================================================
// Module : axis_dac_arbiter_oreg
// Brief  : One-deep AXI4-Stream output register; holds data while the sink
//          stalls and accepts a new beat whenever it is empty or draining.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_dac_arbiter_oreg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  w_load;

    assign o_ready = ~r_valid | i_ready;
    assign w_load  = i_valid & o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/axis_dac_arbiter.sv
// ============================================================================
// Module : axis_dac_arbiter
// Brief  : Grants the DAC sample stream to one of two AXI4-Stream sources in
//          whole bursts with a configurable guard gap between bursts.
//          Define AXIS_DAC_ARBITER_FIXED_PRIO_EN for fixed source-0 priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_dac_arbiter
    import axis_dac_arbiter_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [2*CNTR_WIDTH-1:0]     cfg_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis0_tdata,
    input  logic                        s_axis0_tvalid,
    input  logic                        s_axis0_tlast,
    output logic                        s_axis0_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis1_tdata,
    input  logic                        s_axis1_tvalid,
    input  logic                        s_axis1_tlast,
    output logic                        s_axis1_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [CNTR_WIDTH+1:0]       sts_data
);

    state_t                r_state;
    logic                  r_grant_idx;
    logic                  r_last_idx;
    logic [CNTR_WIDTH-1:0] r_max;
    logic [CNTR_WIDTH-1:0] r_guard;
    logic [CNTR_WIDTH-1:0] r_beat_cnt;
    logic [CNTR_WIDTH-1:0] r_guard_cnt;

    logic [SRC_NUM-1:0]          w_req;
    logic                        w_pick;
    logic                        w_in_grant;
    logic                        w_sel_valid;
    logic                        w_sel_last;
    logic [AXIS_TDATA_WIDTH-1:0] w_sel_data;
    logic                        w_oreg_ready;
    logic                        w_accept;
    logic                        w_release;
    logic [CNTR_WIDTH-1:0]       w_cnt_inc;
    logic [CNTR_WIDTH-1:0]       w_cfg_max;
    logic [CNTR_WIDTH-1:0]       w_cfg_guard;

    assign w_req       = {s_axis1_tvalid, s_axis0_tvalid};
    assign w_cfg_max   = cfg_data[c_cfg_max_idx*CNTR_WIDTH +: CNTR_WIDTH];
    assign w_cfg_guard = cfg_data[c_cfg_guard_idx*CNTR_WIDTH +: CNTR_WIDTH];

    always_comb begin
        w_pick = 1'b0;
`ifdef AXIS_DAC_ARBITER_FIXED_PRIO_EN
        w_pick = ~w_req[0];
`else
        // Both requesting: hand over to whichever source did not own the last burst
        if (&w_req) begin
            w_pick = ~r_last_idx;
        end else begin
            w_pick = ~w_req[0];
        end
`endif
    end

    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_sel_valid = r_grant_idx ? s_axis1_tvalid : s_axis0_tvalid;
    assign w_sel_last  = r_grant_idx ? s_axis1_tlast  : s_axis0_tlast;
    assign w_sel_data  = r_grant_idx ? s_axis1_tdata  : s_axis0_tdata;

    assign s_axis0_tready = w_in_grant & ~r_grant_idx & w_oreg_ready;
    assign s_axis1_tready = w_in_grant &  r_grant_idx & w_oreg_ready;

    assign w_accept  = w_in_grant & w_sel_valid & w_oreg_ready;
    assign w_cnt_inc = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + 1'b1;
    assign w_release = w_accept &
                       (w_sel_last | ((r_max != '0) & (w_cnt_inc == r_max)));

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= 1'b0;
            r_last_idx  <= 1'b1;
            r_max       <= '0;
            r_guard     <= '0;
            r_beat_cnt  <= '0;
            r_guard_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant_idx <= w_pick;
                        r_max       <= w_cfg_max;
                        r_guard     <= w_cfg_guard;
                        r_beat_cnt  <= '0;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_cnt_inc;
                    end
                    if (w_release) begin
                        r_last_idx <= r_grant_idx;
                        // Guard counter is loaded here so GUARD lasts exactly r_guard cycles
                        if (r_guard != '0) begin
                            r_guard_cnt <= r_guard;
                            r_state     <= ST_GUARD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GUARD: begin
                    if (r_guard_cnt <= 1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axis_dac_arbiter_oreg #(
        .DATA_WIDTH (AXIS_TDATA_WIDTH)
    ) u_oreg (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (w_in_grant & w_sel_valid),
        .i_data  (w_sel_data),
        .i_last  (w_sel_last),
        .o_ready (w_oreg_ready),
        .o_valid (m_axis_tvalid),
        .o_data  (m_axis_tdata),
        .o_last  (m_axis_tlast),
        .i_ready (m_axis_tready)
    );

    assign sts_data = {(r_state != ST_IDLE), r_grant_idx, r_beat_cnt};

endmodule

`default_nettype wire

// File: doc/axis_dac_arbiter.md
Name: axis_dac_arbiter

Overview:
- Shares the single DAC sample stream between two AXI4-Stream sample sources, e.g. a tone generator and a burst/playback engine.
- Sits directly upstream of the DAC output stage, which consumes one 32-bit word (two 14-bit channel samples in 16-bit lanes) per aclk.
- Grants whole bursts: a burst ends on tlast or on a configurable maximum length.
- Inserts a configurable guard gap (tvalid low, so the DAC stage outputs zero) between bursts from different or the same sources.

Parameters:
- AXIS_TDATA_WIDTH, 32, sample word width; passed through unmodified.
- CNTR_WIDTH, 16, width of the burst and guard counters.

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous active-high reset.
- cfg_data  input  2*CNTR_WIDTH  [CNTR_WIDTH-1:0] = max burst beats (0 = unlimited); upper half = guard cycles.
- s_axis0_tdata  input  AXIS_TDATA_WIDTH  source 0 data.
- s_axis0_tvalid  input  1  source 0 valid.
- s_axis0_tlast  input  1  source 0 end of burst.
- s_axis0_tready  output  1  source 0 ready.
- s_axis1_tdata, s_axis1_tvalid, s_axis1_tlast, s_axis1_tready: same as source 0, for source 1.
- m_axis_tdata  output  AXIS_TDATA_WIDTH  data to the DAC stage.
- m_axis_tvalid  output  1  valid to the DAC stage.
- m_axis_tlast  output  1  forwarded tlast.
- m_axis_tready  input  1  DAC stage ready (normally tied 1).
- sts_data  output  CNTR_WIDTH+2  {busy, grant_idx, beats accepted in current burst}.

Behaviour:
- Reset (synchronous, areset=1 at posedge):
  - State IDLE.
  - m_axis_tvalid/tlast/tdata = 0.
  - Both s_axis*_tready = 0.
  - grant_idx = 0, last_idx = 1, so source 0 wins first.
  - Counters = 0, sts_data = 0.
  - Reset mid-burst discards the output register contents; nothing is flushed.
- States: IDLE, GRANT, GUARD.
- IDLE:
  - If any s_axis*_tvalid is high, latch the winner into grant_idx, latch cfg_data into internal registers, clear the beat counter, and go to GRANT.
  - Arbitration is round-robin: when both sources are valid, pick the index != last_idx; when one is valid, pick it.
  - Arbitration costs 1 cycle; tready is 0 in IDLE.
- GRANT:
  - s_axisK_tready = (K == grant_idx) & (~m_axis_tvalid | m_axis_tready). The other source's tready stays 0.
  - Accepted beat loads the output register: data-to-output latency is 1 cycle.
  - m_axis_tvalid, tdata and tlast stay stable until m_axis_tready is high.
  - The beat counter increments per accepted beat and saturates at all-ones.
  - Release occurs on the accepted beat with tlast=1, or on the beat that makes the count equal to a nonzero max.
  - On release: last_idx <= grant_idx; next state is GUARD if guard != 0, else IDLE.
  - The release beat is the final accepted beat: tready is 0 from the next cycle.
  - A source dropping tvalid mid-burst keeps the grant. m_axis_tvalid falls once the output register drains, and the DAC stage outputs zero.
- GUARD:
  - Load the guard counter with the latched guard value; decrement per cycle.
  - Go to IDLE when it reaches 1, giving exactly `guard` cycles in GUARD.
  - Any pending output beat still drains normally.
- Simultaneous events:
  - Release with the other source valid: the other source wins the next arbitration.
  - Release with only the same source valid: the same source is regranted after guard + 1 cycle.
- Config writes during a burst have no effect until the next grant.
- sts_data: busy = (state != IDLE).

Optional Feature:
- Macro AXIS_DAC_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, source 0 always wins when both are valid; last_idx is ignored.
- Undefined: round-robin as above.
- Neither setting changes burst, guard or handshake behaviour.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=0, GRANT=1, GUARD=2);
  - SRC_NUM = 2;
  - cfg field offset constants.
- One natural sub-module: axis_dac_arbiter_oreg, the 1-deep output register with valid/ready hold.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset then idle, both tvalid=0 -> all outputs 0 indefinitely; assert areset mid-burst -> next cycle m_axis_tvalid=0, both tready=0, sts_data=0.
- Source 0 sends 4 beats 0x00010001..0x00040004 with tlast on the 4th, max=0, guard=0, m_axis_tready=1 -> same 4 words out with 1-cycle latency; tlast on the 4th; tready falls after the 4th.
- Both sources valid continuously, max=3, guard=2 -> bursts alternate 0,1,0,1 of 3 beats each; exactly 2 + 1 idle cycles of m_axis_tvalid=0 between bursts.
- m_axis_tready toggling 1,0,0,1 during a burst -> m_axis_tdata held stable while stalled; no beat lost or duplicated; counter = accepted beats.
- Source 1 drops tvalid for 5 cycles mid-burst while source 0 is valid -> grant stays on 1; m_axis_tvalid=0 for those cycles; source 0 gets no tready until source 1's tlast.
- With AXIS_DAC_ARBITER_FIXED_PRIO_EN, both continuously valid with tlast every beat -> source 0 granted every time, source 1 never.
